fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/nibbler_pkg.sv | 20 ++
 rtl/fetch_sequencer_pc_reg.sv | 47 ++++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared types and constants for the nibbler fetch sequencer.
// Holds the sequencer state encoding, datapath widths and the PC reset value.
package nibbler_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 4;

    localparam logic [PC_W-1:0] RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

    function automatic logic rise_detect(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// 12-bit program counter with enable, load and increment; load wins over increment.
// pc_next exposes the value pc takes at the next edge so callers can act on it early.
module pc_reg
    import nibbler_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next-PC selection; increment wraps naturally at the top of the address space
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            if (load) begin
                pc_d = load_val;
            end else if (inc) begin
                pc_d = pc_q + 12'h001;
            end else begin
                pc_d = pc_q;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the nibbler core: HALT/FETCH/EXEC control with
// free-run, single-step and PC breakpoint support.
module fetch_sequencer
    import nibbler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step_req,
    input  logic [7:0]         prog_byte,
    input  logic               inc_pc,
    input  logic               load_pc,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    output logic [PC_W-1:0]    pc,
    output logic               phase,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] operand,
    output logic               dp_en,
    output logic               halted,
    output logic               step_ack,
    output logic               bp_hit
);

    seq_state_e      state_q, state_d;
    logic            single_q, single_d;
    logic            step_prev_q, step_prev_d;
    logic [7:0]      fetch_q, fetch_d;
    logic            step_ack_q, step_ack_d;
    logic            bp_hit_q, bp_hit_d;
    logic            phase_q, phase_d;
    logic            dp_en_q, dp_en_d;
    logic            halted_q, halted_d;

    logic            pc_en;
    logic [PC_W-1:0] pc_next;
    logic            step_edge;
    logic            bp_match;

    assign pc_en     = (state_q != ST_HALT);
    assign step_edge = rise_detect(step_req, step_prev_q);
    // The breakpoint looks at the address the PC is about to take, not the current one
    assign bp_match  = bp_en && (pc_next == bp_addr);

    pc_reg u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (pc_en),
        .load     (load_pc),
        .inc      (inc_pc),
        .load_val ({fetch_q[3:0], prog_byte}),
        .pc       (pc),
        .pc_next  (pc_next)
    );

    // Next-state, fetch register, step/breakpoint bookkeeping and output decode
    always_comb begin
        state_d     = state_q;
        single_d    = single_q;
        fetch_d     = fetch_q;
        step_ack_d  = 1'b0;
        bp_hit_d    = bp_hit_q;
        step_prev_d = step_req;

        case (state_q)
            ST_HALT: begin
                if (run) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b0;
                    bp_hit_d = 1'b0;
                end else if (step_edge) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b1;
                    bp_hit_d = 1'b0;
                end else begin
                    state_d  = ST_HALT;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
                fetch_d = prog_byte;
            end
            ST_EXEC: begin
                if (bp_match) begin
                    bp_hit_d = 1'b1;
                end else begin
                    bp_hit_d = bp_hit_q;
                end
                if (run && !single_q && !bp_match) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d    = ST_HALT;
                    step_ack_d = single_q;
                    single_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_HALT;
                single_d = 1'b0;
            end
        endcase

        phase_d  = (state_d == ST_EXEC);
        dp_en_d  = (state_d != ST_HALT);
        halted_d = (state_d == ST_HALT);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALT;
            single_q    <= 1'b0;
            step_prev_q <= 1'b0;
            fetch_q     <= 8'h00;
            step_ack_q  <= 1'b0;
            bp_hit_q    <= 1'b0;
            phase_q     <= 1'b0;
            dp_en_q     <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            single_q    <= single_d;
            step_prev_q <= step_prev_d;
            fetch_q     <= fetch_d;
            step_ack_q  <= step_ack_d;
            bp_hit_q    <= bp_hit_d;
            phase_q     <= phase_d;
            dp_en_q     <= dp_en_d;
            halted_q    <= halted_d;
        end
    end

    assign phase    = phase_q;
    assign instr    = fetch_q[7:4];
    assign operand  = fetch_q[3:0];
    assign dp_en    = dp_en_q;
    assign halted   = halted_q;
    assign step_ack = step_ack_q;
    assign bp_hit   = bp_hit_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle model of the sequencer rules,
// a per-cycle output compare, directed scenarios with literal checks, then random stimulus.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic [7:0]  prog_byte = 8'h00;
    logic        inc_pc = 1'b0;
    logic        load_pc = 1'b0;
    logic        bp_en = 1'b0;
    logic [11:0] bp_addr = 12'h000;
    logic [11:0] pc;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic        dp_en;
    logic        halted;
    logic        step_ack;
    logic        bp_hit;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req),
        .prog_byte(prog_byte), .inc_pc(inc_pc), .load_pc(load_pc),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .phase(phase),
        .instr(instr), .operand(operand), .dp_en(dp_en), .halted(halted),
        .step_ack(step_ack), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = halted, 1 = fetching, 2 = executing
    int       m_mode = 0;
    int       m_pc = 0;
    int       m_fetch = 0;
    bit       m_single = 1'b0;
    bit       m_prev = 1'b0;
    bit       m_ack = 1'b0;
    bit       m_bp = 1'b0;

    always @(posedge clk) begin
        int  npc;
        bit  edge_seen;
        bit  hit;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_fetch = 0; m_single = 0;
            m_prev = 0; m_ack = 0; m_bp = 0;
        end else begin
            edge_seen = step_req && !m_prev;
            m_prev = step_req;
            m_ack = 0;
            npc = m_pc;
            if (m_mode != 0) begin
                if (load_pc) npc = (m_fetch % 16) * 256 + prog_byte;
                else if (inc_pc) npc = (m_pc + 1) % 4096;
            end
            if (m_mode == 0) begin
                if (run || edge_seen) begin
                    m_mode = 1; m_single = !run; m_bp = 0;
                end
            end else if (m_mode == 1) begin
                m_fetch = prog_byte;
                m_mode = 2;
            end else begin
                hit = bp_en && (npc == bp_addr);
                if (hit) m_bp = 1;
                if (run && !m_single && !hit) m_mode = 1;
                else begin
                    m_mode = 0; m_ack = m_single; m_single = 0;
                end
            end
            m_pc = npc;
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [24:0] exp_v;
        logic [24:0] act_v;
        if (chk_en) begin
            exp_v = {m_pc[11:0], (m_mode == 2), m_fetch[7:0], (m_mode != 0),
                     (m_mode == 0), m_ack, m_bp};
            act_v = {pc, phase, instr, operand, dp_en, halted, step_ack, bp_hit};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL outputs t=%0t got=%h expected=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp_val);
        total++;
        if (act !== exp_val) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp_val);
        end
    endtask

    task automatic do_step(input logic [7:0] fb, input bit finc, input bit fload,
                           input logic [7:0] eb, input bit einc, input bit eload);
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0; prog_byte = fb; inc_pc = finc; load_pc = fload;
        cyc(1);
        prog_byte = eb; inc_pc = einc; load_pc = eload;
        cyc(1);
        inc_pc = 1'b0; load_pc = 1'b0;
    endtask

    initial begin
        int guard;
        cyc(1);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 1);
        chk("rst_dp_en", dp_en, 0);
        chk("rst_phase", phase, 0);

        // Free run with 0x35 and inc in FETCH
        run = 1'b1; prog_byte = 8'h35;
        cyc(1);
        inc_pc = 1'b1;
        cyc(1);
        inc_pc = 1'b0;
        chk("run_phase_exec", phase, 1);
        chk("run_instr", instr, 3);
        chk("run_operand", operand, 5);
        chk("run_pc", pc, 12'h001);
        cyc(1);
        chk("run_phase_fetch", phase, 0);
        run = 1'b0;
        cyc(1);
        chk("run_drop_exec", phase, 1);
        cyc(1);
        chk("run_drop_halt", halted, 1);

        // Single step with increment
        do_step(8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("step_ack_pulse", step_ack, 1);
        chk("step_halted", halted, 1);
        chk("step_pc", pc, 12'h002);
        cyc(1);
        chk("step_ack_clear", step_ack, 0);
        chk("step_stays_halted", halted, 1);

        // Wrap and load priority
        do_step(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
        chk("load_fff", pc, 12'hFFF);
        do_step(8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_pc", pc, 12'h000);
        do_step(8'h5A, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1);
        chk("load_prio_pc", pc, 12'hABC);

        // Breakpoint at 0x004 from pc 0
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; bp_en = 1'b1; bp_addr = 12'h004; run = 1'b1; inc_pc = 1'b1;
        guard = 0;
        cyc(1);
        while (m_mode != 0 && guard < 20) begin
            cyc(1);
            guard++;
        end
        run = 1'b0; inc_pc = 1'b0;
        chk("bp_wait_bound", (guard < 20) ? 1 : 0, 1);
        chk("bp_pc", pc, 12'h004);
        chk("bp_hit_set", bp_hit, 1);
        cyc(1);
        chk("bp_hit_sticky", bp_hit, 1);
        run = 1'b1;
        cyc(1);
        chk("bp_hit_cleared", bp_hit, 0);
        run = 1'b0; bp_en = 1'b0;
        cyc(2);

        // Reset in the middle of EXEC
        run = 1'b1; prog_byte = 8'h7E;
        cyc(2);
        chk("mid_exec_phase", phase, 1);
        reset = 1'b1; inc_pc = 1'b1; load_pc = 1'b1;
        cyc(1);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_halted", halted, 1);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_dp_en", dp_en, 0);
        chk("mid_rst_fetch", {instr, operand}, 0);
        reset = 1'b0; run = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
        cyc(1);

        // Randomized stimulus checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
            step_req  = ($urandom_range(0, 2) == 0);
            prog_byte = 8'($urandom);
            inc_pc    = ($urandom_range(0, 3) != 0);
            load_pc   = ($urandom_range(0, 15) == 0);
            bp_en     = $urandom_range(0, 1);
            bp_addr   = 12'($urandom_range(0, 15));
            cyc(1);
        end
        reset = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
